// File: rtl/bus_arbiter_n.sv
// N-channel bus arbiter: latches per-channel requests, grants one at a time to a shared slave.
// Ports: clk/rstn, m_* per-channel master side, s_* shared slave side. Option macro: BUS_ARB_RR_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module bus_arbiter_n #(
  parameter int CH_CNT = 2
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [CH_CNT*`XLEN-1:0]                m_addr,
  input  logic [CH_CNT-1:0]                      m_w_rb,
  input  logic [CH_CNT*$clog2(`BUS_ACC_CNT)-1:0] m_acc,
  input  logic [CH_CNT*`BUS_WIDTH-1:0]           m_wdata,
  input  logic [CH_CNT-1:0]                      m_req,
  output logic [CH_CNT-1:0]                      m_resp,
  output logic [CH_CNT*`BUS_WIDTH-1:0]           m_rdata,
  output logic [CH_CNT-1:0]                      m_fault,
  output logic [`XLEN-1:0]                       s_addr,
  output logic                                   s_w_rb,
  output logic [$clog2(`BUS_ACC_CNT)-1:0]        s_acc,
  output logic [`BUS_WIDTH-1:0]                  s_wdata,
  output logic                                   s_req,
  input  logic [`BUS_WIDTH-1:0]                  s_rdata,
  input  logic                                   s_resp,
  input  logic                                   s_fault
);

  localparam int XW = `XLEN;
  localparam int BW = `BUS_WIDTH;
  localparam int AW = $clog2(`BUS_ACC_CNT);
  localparam int IW = $clog2(CH_CNT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [CH_CNT-1:0] pend;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win;
  logic            any;
  logic [XW-1:0]   addr_q  [CH_CNT];
  logic            w_rb_q  [CH_CNT];
  logic [AW-1:0]   acc_q   [CH_CNT];
  logic [BW-1:0]   wdata_q [CH_CNT];

  assign any = |pend;

`ifdef BUS_ARB_RR_EN
  logic [IW-1:0] ptr;

  // Descending walk: the last hit is the channel closest after ptr.
  always_comb begin
    int j;
    j = 0;
    win = '0;
    for (int off = CH_CNT; off >= 1; off--) begin
      j = (int'(ptr) + off) % CH_CNT;
      if (pend[j]) win = IW'(j);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= IW'(CH_CNT - 1);
    else if (state == IDLE && any) ptr <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int i = CH_CNT - 1; i >= 0; i--)
      if (pend[i]) win = IW'(i);
  end
`endif

  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_w_rb  = 1'b0;
    s_acc   = '0;
    s_wdata = '0;
    if (state == IDLE && any) begin
      s_req   = 1'b1;
      s_addr  = addr_q[win];
      s_w_rb  = w_rb_q[win];
      s_acc   = acc_q[win];
      s_wdata = wdata_q[win];
    end
  end

  always_comb begin
    m_resp  = '0;
    m_rdata = '0;
    m_fault = '0;
    if (state == WAIT && s_resp) begin
      m_resp[owner]          = 1'b1;
      m_fault[owner]         = s_fault;
      m_rdata[owner*BW +: BW] = s_rdata;
    end
  end

  // Slot stays set while in flight; a request in the response cycle re-arms it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pend  <= '0;
      owner <= '0;
      for (int k = 0; k < CH_CNT; k++) begin
        addr_q[k]  <= '0;
        w_rb_q[k]  <= 1'b0;
        acc_q[k]   <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH_CNT; k++) begin
        if (m_req[k] && (!pend[k] || m_resp[k])) begin
          pend[k]    <= 1'b1;
          addr_q[k]  <= m_addr[k*XW +: XW];
          w_rb_q[k]  <= m_w_rb[k];
          acc_q[k]   <= m_acc[k*AW +: AW];
          wdata_q[k] <= m_wdata[k*BW +: BW];
        end else if (m_resp[k]) begin
          pend[k] <= 1'b0;
        end
      end
      unique case (state)
        IDLE: if (any) begin
          owner <= win;
          state <= WAIT;
        end
        WAIT: if (s_resp) state <= IDLE;
      endcase
    end
  end

endmodule
